// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: instruction and PC widths, bubble encoding,
// fetch FSM states and the IF/ID pipeline register layout.
package fetch_pkg;

    localparam int INSTR_W = 20;
    localparam int PC_W    = 15;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 20'h00000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus1;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: flush loads a bubble and takes priority over stall.
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t BUBBLE = '{
        instr:    BUBBLE_INSTR,
        pc:       '0,
        pc_plus1: '0,
        valid:    1'b0
    };

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: program counter, synchronous-ROM addressing, IF/ID register
// and a saturating count of instructions delivered to decode.
module fetch_stage #(
    parameter int                 INSTR_W   = fetch_pkg::INSTR_W,
    parameter int                 PC_W      = fetch_pkg::PC_W,
    parameter logic [PC_W-1:0]    RESET_PC  = 15'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [PC_W-1:0]    PCTargetE,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCD,
    output logic [PC_W-1:0]    PCPlus1D,
    output logic               ValidD,
    output logic [CNT_W-1:0]   fetch_count
);

    import fetch_pkg::*;

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc_f, pc_next;
    logic            boot_flush, flush, load_valid;
    logic [CNT_W-1:0] count;
    if_id_t          if_id_d, if_id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = RUN;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // The ROM is always addressed with the PC that will be current after the
    // edge, so its registered output lines up with pc_f without a skid buffer.
    always_comb begin
        pc_next    = pc_f;
        imem_addr  = RESET_PC;
        boot_flush = 1'b1;
        if (state == RUN) begin
            boot_flush = 1'b0;
            if (PCSrcE) begin
                pc_next = PCTargetE;
            end else if (StallF) begin
                pc_next = pc_f;
            end else begin
                pc_next = pc_f + 1'b1;
            end
            imem_addr = pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= pc_next;
        end
    end

    assign flush      = FlushD || boot_flush;
    assign load_valid = !flush && !StallD;

    always_comb begin
        if_id_d.instr    = imem_rdata;
        if_id_d.pc       = pc_f;
        if_id_d.pc_plus1 = pc_f + 1'b1;
        if_id_d.valid    = 1'b1;
    end

    if_id_register #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .stall (StallD),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load_valid && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign InstrD      = if_id_q.instr;
    assign PCD         = if_id_q.pc;
    assign PCPlus1D    = if_id_q.pc_plus1;
    assign ValidD      = if_id_q.valid;
    assign fetch_count = count;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the 5-stage pipeline: owns the program counter, drives a synchronous instruction ROM and loads the IF/ID pipeline register that feeds the decode stage (InstrD, PCD).
- Honors stall/flush from the hazard unit and branch/jump redirects from execute.
- Counts instructions delivered to decode, for performance visibility.

Parameters:
- INSTR_W, 20, instruction width.
- PC_W, 15, PC / instruction-address width (word addressed, +1 per instruction).
- RESET_PC, 15'h0000, first fetch address after reset.
- NOP_INSTR, 20'h00000, bubble encoding; all control signals decode to 0.
- CNT_W, 16, fetch counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  load a bubble into IF/ID.
- PCSrcE  in  1  redirect taken in execute.
- PCTargetE  in  PC_W  redirect target.
- imem_addr  out  PC_W  ROM read address (combinational).
- imem_rdata  in  INSTR_W  ROM data, 1-cycle latency: rdata(t+1) = mem[imem_addr(t)].
- InstrD  out  INSTR_W  instruction to decode.
- PCD  out  PC_W  PC of InstrD.
- PCPlus1D  out  PC_W  PCD+1, for link/jump.
- ValidD  out  1  IF/ID holds a real instruction.
- fetch_count  out  CNT_W  instructions delivered (saturating).

Behaviour:
- Reset (async, reset==0):
  - PCF=RESET_PC, state=BOOT.
  - InstrD=NOP_INSTR, PCD=0, PCPlus1D=0, ValidD=0, fetch_count=0.
  - Reset asserted mid-operation discards everything in flight; there is no partial state.
- States:
  - BOOT: exactly one cycle after reset release. imem_addr=RESET_PC; PCF holds; IF/ID loads the bubble. Unconditional transition to RUN.
  - RUN: steady state. RUN -> BOOT only on reset.
- PCnext in RUN, priority order:
  - PCSrcE: PCTargetE.
  - else StallF: PCF.
  - else: PCF+1, mod 2^PC_W, so 15'h7FFF wraps to 15'h0000.
- Addressing in RUN:
  - imem_addr=PCnext; PCF<=PCnext every edge.
  - imem_rdata therefore always corresponds to current PCF; no skid buffer is needed.
  - Under StallF the ROM re-reads PCF, so data is stable.
- IF/ID update on each edge, priority order:
  - FlushD or state==BOOT: InstrD=NOP_INSTR, PCD=0, PCPlus1D=0, ValidD=0.
  - else StallD: hold all IF/ID fields.
  - else: InstrD=imem_rdata, PCD=PCF, PCPlus1D=PCF+1 (wrapping), ValidD=1.
- Hazard-unit contract: StallD implies StallF. StallD && !StallF is illegal (bench assertion); RTL behaviour is then undefined.
- Simultaneous events:
  - PCSrcE with StallF: redirect wins, PCF<=PCTargetE. The hazard unit asserts FlushD with PCSrcE.
  - FlushD with StallD: flush wins.
- Latency:
  - Reset release to first ValidD=1: 2 edges (BOOT edge, then first capture).
  - Redirect to target in InstrD: 2 edges (PCF load, then capture); the intervening slot is flushed.
- fetch_count:
  - Increments on each edge where IF/ID loads with ValidD<=1.
  - Saturates at 2^CNT_W-1.
  - Holds under stall and flush.

Decomposition:
- Shared package (fetch_pkg): INSTR_W, PC_W, NOP_INSTR, the state enum {BOOT, RUN}, and an if_id_t struct {instr, pc, pc_plus1, valid}. Decode uses the same widths.
- One sub-module, if_id_register: holds if_id_t with async active-low reset, flush and stall inputs, and flush-over-stall priority.
- PC logic, FSM and counter stay in fetch_stage.

Test Plan:
- Reset release, ROM[i]=20'h00010+i:
  - imem_addr=0 in BOOT.
  - ValidD=1, InstrD=20'h00010, PCD=0, PCPlus1D=1 after 2nd edge.
  - PCD steps 1, 2, 3 on following edges; fetch_count=1, 2, 3, 4.
- Stall at PCF=5, StallF=StallD=1 for 3 cycles:
  - InstrD/PCD frozen at PCD=4; imem_addr=5.
  - On release the next PCD=5 with InstrD=ROM[5]; no skipped or duplicated PCs; fetch_count holds during the stall.
- Redirect: PCSrcE=1, PCTargetE=15'h0100, FlushD=1 for one cycle:
  - Next edge ValidD=0, InstrD=NOP_INSTR.
  - Following edge PCD=15'h0100, InstrD=ROM[0x100].
- Redirect with StallF=1 in the same cycle: PCF<=15'h0100 regardless of StallF.
- Wrap: run through PCF=15'h7FFF: PCD=15'h7FFF with PCPlus1D=15'h0000, then next PCD=15'h0000.
- Async reset asserted mid-stream between edges:
  - Outputs clear immediately, without waiting for a clock edge: ValidD=0, fetch_count=0.
  - After release the BOOT sequence repeats from RESET_PC.
